// File: rtl/even_div_sequencer.sv
// even_div_sequencer: run-time controller for an even, 50%-duty clock divider.
// Ratio changes arrive over a valid/ready handshake. While the divider runs,
// a change is applied only at an output-period boundary, so div_out never
// produces a runt pulse.
module even_div_sequencer #(
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned DEFAULT_HALF = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_half,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             div_out,
   output logic             period_start,
   output logic [CNT_W-1:0] cur_half
);

   // The counter is one bit wider than the half-period so that 2*half-1 fits
   // without overflow.
   localparam int unsigned CW = CNT_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [CNT_W-1:0] pend_half;
   logic             pend_vld;

   logic [CW-1:0]    last_cnt;
   logic             at_last;
   logic             accept;
   logic             half_zero;
   logic             good_req;

   // Last count of the current period; cur_half is never zero, so this
   // cannot underflow.
   assign last_cnt  = {cur_half, 1'b0} - CW'(1);
   assign at_last   = (cnt >= last_cnt);

   // Handshake: a request can be taken whenever no change is pending.
   assign cfg_ready = (state != PEND);
   assign accept    = cfg_valid & cfg_ready;
   assign half_zero = (cfg_half == '0);
   assign good_req  = accept & ~half_zero;

   // Output decode from the registered counter; en gates both so idle is clean.
   assign div_out      = en & (cnt != '0) & (cnt <= {1'b0, cur_half});
   assign period_start = en & (cnt == '0);

   // Counter, ratio and pending-change state machine.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= '0;
         cur_half  <= CNT_W'(DEFAULT_HALF);
         pend_half <= '0;
         pend_vld  <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         // Zero half-period requests are consumed but dropped.
         cfg_err <= accept & half_zero;

         if (!en) begin
            // Idle: hold the counter and apply any change directly, since
            // there is no waveform to protect.
            state    <= IDLE;
            cnt      <= '0;
            pend_vld <= 1'b0;
            if (good_req) begin
               cur_half <= cfg_half;
            end else if (pend_vld) begin
               cur_half <= pend_half;
            end
         end else begin
            cnt <= at_last ? '0 : cnt + CW'(1);
            unique case (state)
               IDLE, RUN: begin
                  if (good_req) begin
                     pend_half <= cfg_half;
                     pend_vld  <= 1'b1;
                     state     <= PEND;
                  end else begin
                     state <= RUN;
                  end
               end
               PEND: begin
                  // Swap the ratio exactly as the new period begins.
                  if (at_last) begin
                     cur_half <= pend_half;
                     pend_vld <= 1'b0;
                     state    <= RUN;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_even_div_sequencer.sv
// tb_even_div_sequencer: directed scoreboard bench for even_div_sequencer.
module tb_even_div_sequencer;

   logic       clk;
   logic       resetn;
   logic       en;
   logic       cfg_valid;
   logic [7:0] cfg_half;
   logic       cfg_ready;
   logic       cfg_err;
   logic       div_out;
   logic       period_start;
   logic [7:0] cur_half;

   int n_tests = 0;
   int n_fail  = 0;
   int cur_tag = 0;

   typedef struct packed {
      logic [7:0] tag;
      logic       d;
      logic       p;
      logic [7:0] h;
      logic       r;
      logic       e;
   } exp_t;

   exp_t q[$];

   even_div_sequencer #(.CNT_W(8), .DEFAULT_HALF(1)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .en           (en),
      .cfg_valid    (cfg_valid),
      .cfg_half     (cfg_half),
      .cfg_ready    (cfg_ready),
      .cfg_err      (cfg_err),
      .div_out      (div_out),
      .period_start (period_start),
      .cur_half     (cur_half)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (test %0d) at %0t: got %0h, expected %0h", nm, tag, $time, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected in that cycle.
   task automatic step(input logic e, input logic v, input logic [7:0] h,
                       input logic xd, input logic xp, input logic [7:0] xh,
                       input logic xr, input logic xe);
      exp_t x;
      en        = e;
      cfg_valid = v;
      cfg_half  = h;
      x.tag = 8'(cur_tag);
      x.d   = xd;
      x.p   = xp;
      x.h   = xh;
      x.r   = xr;
      x.e   = xe;
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pop one expectation per cycle and compare mid-cycle.
   always @(negedge clk) begin
      exp_t x;
      if (q.size() != 0) begin
         x = q.pop_front();
         cmp("div_out",      int'(x.tag), 32'(div_out),      32'(x.d));
         cmp("period_start", int'(x.tag), 32'(period_start), 32'(x.p));
         cmp("cur_half",     int'(x.tag), 32'(cur_half),     32'(x.h));
         cmp("cfg_ready",    int'(x.tag), 32'(cfg_ready),    32'(x.r));
         cmp("cfg_err",      int'(x.tag), 32'(cfg_err),      32'(x.e));
      end
   end

   initial begin
      resetn    = 1'b0;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_half  = 8'd0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      cur_tag = 0;
      step(0,0,0,   0,0,1,1,0);
      resetn = 1'b1;

      // 1: divide-by-2 after reset
      cur_tag = 1;
      for (int k = 0; k < 7; k++) step(1,0,0, (k%2)==1, (k%2)==0, 1,1,0);

      // 2: request half=3 on last cycle of a period -> applies at following boundary
      cur_tag = 2;
      step(1,1,3,   1,0,1,1,0);
      step(1,0,0,   0,1,1,0,0);
      step(1,0,0,   1,0,1,0,0);
      step(1,0,0,   0,1,3,1,0);

      // 3: equal-half request goes through PEND; held request waits for ready
      cur_tag = 3;
      step(1,1,3,   1,0,3,1,0);
      step(1,1,2,   1,0,3,0,0);
      step(1,1,2,   1,0,3,0,0);
      step(1,1,2,   0,0,3,0,0);
      step(1,1,2,   0,0,3,0,0);
      step(1,1,2,   0,1,3,1,0);
      step(1,0,0,   1,0,3,0,0);
      step(1,0,0,   1,0,3,0,0);
      step(1,0,0,   1,0,3,0,0);
      step(1,0,0,   0,0,3,0,0);
      step(1,0,0,   0,0,3,0,0);
      step(1,0,0,   0,1,2,1,0);
      step(1,0,0,   1,0,2,1,0);
      step(1,0,0,   1,0,2,1,0);
      step(1,0,0,   0,0,2,1,0);

      // 4: zero half request -> one-cycle error, nothing else changes
      cur_tag = 4;
      step(1,1,0,   0,1,2,1,0);
      step(1,0,0,   1,0,2,1,1);
      step(1,0,0,   1,0,2,1,0);
      step(1,0,0,   0,0,2,1,0);

      // 5: go to half=3, drop en while high, re-raise
      cur_tag = 5;
      step(1,1,3,   0,1,2,1,0);
      step(1,0,0,   1,0,2,0,0);
      step(1,0,0,   1,0,2,0,0);
      step(1,0,0,   0,0,2,0,0);
      step(1,0,0,   0,1,3,1,0);
      step(1,0,0,   1,0,3,1,0);
      step(0,0,0,   0,0,3,1,0);
      step(0,0,0,   0,0,3,1,0);
      step(1,0,0,   0,1,3,1,0);
      step(1,0,0,   1,0,3,1,0);
      step(1,0,0,   1,0,3,1,0);
      step(1,0,0,   1,0,3,1,0);
      step(1,0,0,   0,0,3,1,0);
      step(1,0,0,   0,0,3,1,0);
      step(1,0,0,   0,1,3,1,0);

      // 7: idle request applies in one cycle; en drop during PEND applies pending
      cur_tag = 7;
      step(0,1,1,   0,0,3,1,0);
      step(0,0,0,   0,0,1,1,0);
      step(1,1,2,   0,1,1,1,0);
      step(0,0,0,   0,0,1,0,0);
      step(0,0,0,   0,0,2,1,0);

      // 8: maximum half-period, counter runs to 509 and wraps
      cur_tag = 8;
      step(0,1,255, 0,0,2,1,0);
      for (int i = 0; i < 512; i++) begin
         int c;
         c = i % 510;
         step(1,0,0, (c >= 1) && (c <= 255), c == 0, 255,1,0);
      end

      // 6: async reset in the middle of PEND
      cur_tag = 6;
      step(1,1,5,   1,0,255,1,0);
      step(1,0,0,   1,0,255,0,0);
      #3;
      resetn = 1'b0;
      #1;
      cmp("async_div_out",   6, 32'(div_out),   32'(0));
      cmp("async_cur_half",  6, 32'(cur_half),  32'(1));
      cmp("async_cfg_ready", 6, 32'(cfg_ready), 32'(1));
      cmp("async_cfg_err",   6, 32'(cfg_err),   32'(0));
      @(posedge clk);
      #1;
      resetn = 1'b1;
      for (int k = 0; k < 14; k++) step(1,0,0, (k%2)==1, (k%2)==0, 1,1,0);

      en        = 1'b0;
      cfg_valid = 1'b0;
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
